// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC sequencer for the combinational InstructionMemory ROM with a prefetch FIFO
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous active-high reset
//   enable         in   1   1 = fetch allowed; 0 = stop issuing fetches (FIFO still drains)
//   mem_address    out  32  ROM word address (equals pc)
//   mem_data       in   32  ROM data for mem_address, same cycle
//   redirect_valid in   1   flush and restart fetch at redirect_pc
//   redirect_pc    in   32  new word address
//   instr_valid    out  1   FIFO head valid
//   instr_ready    in   1   decode accepts head when instr_valid & instr_ready
//   instr          out  32  FIFO head instruction word
//   instr_pc       out  32  FIFO head PC
//   halted         out  1   fetch ended (pc out of range) and FIFO empty
module instruction_fetch_unit #(
    parameter int          LENGTH   = 32,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted
);
    localparam int          AW   = $clog2(DEPTH);
    localparam int          CW   = $clog2(DEPTH + 1);
    localparam logic [31:0] LEN  = 32'(LENGTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_END} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   fifo_pc_q[DEPTH];
    logic [31:0]   fifo_data_q[DEPTH];
    logic          push, pop;

    always_comb begin
        pop     = (cnt_q != '0) && instr_ready;
        // a full FIFO still accepts a push when the head leaves in the same cycle
        push    = !redirect_valid && state_q == S_FETCH && pc_q < LEN && (cnt_q < FULL || pop);
        pc_d    = redirect_valid ? redirect_pc : push ? pc_q + 32'd1 : pc_q;
        wr_d    = redirect_valid ? '0 : push ? wr_q + AW'(1) : wr_q;
        rd_d    = redirect_valid ? '0 : pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
        // FETCH ends as soon as the next pc to fetch falls outside the ROM
        state_d = redirect_valid      ? (redirect_pc >= LEN ? S_END : enable ? S_FETCH : S_IDLE) :
                  state_q == S_IDLE   ? (enable ? (pc_q < LEN ? S_FETCH : S_END) : S_IDLE) :
                  state_q == S_FETCH  ? (pc_d >= LEN ? S_END : enable ? S_FETCH : S_IDLE) :
                  state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            if (push) begin
                fifo_pc_q[wr_q]   <= pc_q;
                fifo_data_q[wr_q] <= mem_data;
            end
        end
    end

    assign mem_address = pc_q;
    assign instr_valid = cnt_q != '0;
    assign instr       = fifo_data_q[rd_q];
    assign instr_pc    = fifo_pc_q[rd_q];
    assign halted      = state_q == S_END && cnt_q == '0;
endmodule
